// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port cache arbiter: FSM encoding and default widths.
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int AW_DEF  = 8;
    localparam int DW_DEF  = 8;
    localparam int TIMER_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // NOTE: every output gets a value on every path of always_comb, otherwise a latch is inferred.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and single-transaction sequencer in front of the cache port,
// with a watchdog that aborts a WAIT the cache never answers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 31,
    parameter int CNTW    = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            p0_req,
    input  logic            p0_wren,
    input  logic [AW-1:0]   p0_addr,
    input  logic [DW-1:0]   p0_wdata,
    output logic            p0_ack,
    output logic [DW-1:0]   p0_rdata,
    input  logic            p1_req,
    input  logic            p1_wren,
    input  logic [AW-1:0]   p1_addr,
    input  logic [DW-1:0]   p1_wdata,
    output logic            p1_ack,
    output logic [DW-1:0]   p1_rdata,
    output logic            c_req,
    output logic            c_wren,
    output logic [AW-1:0]   c_addr,
    output logic [DW-1:0]   c_wdata,
    input  logic            c_ready,
    input  logic [DW-1:0]   c_rdata,
    output logic            busy,
    output logic            err,
    output logic [CNTW-1:0] gnt0_cnt,
    output logic [CNTW-1:0] gnt1_cnt
);

    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);

    logic [1:0]         state;
    logic               last_gnt;
    logic               cur_id;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               pick_valid;
    logic               pick_id;

    rr_pick2 u_pick (
        .req       ({p1_req, p0_req}),
        .last      (last_gnt),
        .gnt_valid (pick_valid),
        .gnt_id    (pick_id)
    );

    always_comb begin
        timer_nxt = (timer == '1) ? timer : timer + TIMER_W'(1);
        c_req     = (state == ISSUE);
        busy      = (state != IDLE);
        p0_ack    = (state == RESP) && !cur_id;
        p1_ack    = (state == RESP) && cur_id;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cur_id   <= 1'b0;
            timer    <= '0;
            c_wren   <= 1'b0;
            c_addr   <= '0;
            c_wdata  <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            err      <= 1'b0;
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_id   <= pick_id;
                        last_gnt <= pick_id;
                        c_wren   <= pick_id ? p1_wren  : p0_wren;
                        c_addr   <= pick_id ? p1_addr  : p0_addr;
                        c_wdata  <= pick_id ? p1_wdata : p0_wdata;
                        if (pick_id) gnt1_cnt <= gnt1_cnt + CNTW'(1);
                        else         gnt0_cnt <= gnt0_cnt + CNTW'(1);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Read data lands in the port register here so it is already valid during the ack.
                    if (c_ready) begin
                        if (cur_id) p1_rdata <= c_rdata;
                        else        p0_rdata <= c_rdata;
                        state <= RESP;
                    end else begin
                        timer <= timer_nxt;
                        if (timer_nxt == TIMEOUT_C) begin
                            err <= 1'b1;
                            if (cur_id) p1_rdata <= '0;
                            else        p0_rdata <= '0;
                            state <= RESP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
